// File: rtl/bcd_display_scanner_if.sv
// rtl/bcd_display_scanner_if.sv - time bus and display pin bundle for the BCD display scanner
interface bcd_display_scanner_if;
   logic        en;
   logic [13:0] count_in;
   logic [3:0]  blink_mask;
   logic [3:0]  anode;
   logic [6:0]  seg;
   logic        dp;

   modport master (
      output en, count_in, blink_mask,
      input  anode, seg, dp
   );

   modport slave (
      input  en, count_in, blink_mask,
      output anode, seg, dp
   );
endinterface

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - HH:MM packed-BCD validator and 4-digit multiplexed 7-segment driver
// Optional macro LEADING_ZERO_BLANK_EN darkens a zero hour-tens digit on a valid time.
module bcd_display_scanner #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 50000000
) (
   input  logic clk,
   input  logic rst,
   bcd_display_scanner_if.slave bus
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [RW-1:0] r_ref_cnt;
   logic [1:0]    r_digit_idx;
   logic [13:0]   r_snapshot;
   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_phase;
   logic [3:0]    r_anode;
   logic [6:0]    r_seg;
   logic          r_dp;

   logic          w_ref_wrap;
   logic          w_blink_wrap;
   logic [3:0]    w_d0, w_d1, w_d2, w_d3;
   logic [3:0]    w_cur_digit;
   logic          w_valid;
   logic [3:0]    w_onehot_n;
   logic [3:0]    w_anode_nxt;
   logic [6:0]    w_seg_nxt;
   logic          w_dp_nxt;

   function automatic logic [6:0] f_decode(input logic [3:0] v);
      case (v)
         4'd0:    f_decode = 7'b1000000;
         4'd1:    f_decode = 7'b1111001;
         4'd2:    f_decode = 7'b0100100;
         4'd3:    f_decode = 7'b0110000;
         4'd4:    f_decode = 7'b0011001;
         4'd5:    f_decode = 7'b0010010;
         4'd6:    f_decode = 7'b0000010;
         4'd7:    f_decode = 7'b1111000;
         4'd8:    f_decode = 7'b0000000;
         4'd9:    f_decode = 7'b0010000;
         default: f_decode = 7'b0111111;
      endcase
   endfunction

   assign w_ref_wrap   = (r_ref_cnt == RW'(REFRESH_DIV - 1));
   assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_DIV - 1));

   // Snapshot reloads only at the end of digit 3's slot, so a frame never mixes two times.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ref_cnt   <= '0;
         r_digit_idx <= 2'd0;
         r_snapshot  <= 14'd0;
      end else if (w_ref_wrap) begin
         r_ref_cnt   <= '0;
         r_digit_idx <= r_digit_idx + 2'd1;
         if (r_digit_idx == 2'd3)
            r_snapshot <= bus.count_in;
      end else begin
         r_ref_cnt <= r_ref_cnt + RW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (w_blink_wrap) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + BW'(1);
      end
   end

   assign w_d3 = {1'b0, r_snapshot[13:11]};
   assign w_d2 = r_snapshot[10:7];
   assign w_d1 = {1'b0, r_snapshot[6:4]};
   assign w_d0 = r_snapshot[3:0];

   assign w_valid = !((w_d3 > 4'd2) || (w_d2 > 4'd9) ||
                      ((w_d3 == 4'd2) && (w_d2 > 4'd3)) ||
                      (w_d1 > 4'd5) || (w_d0 > 4'd9));

   always_comb begin
      w_cur_digit = w_d0;
      case (r_digit_idx)
         2'd0: w_cur_digit = w_d0;
         2'd1: w_cur_digit = w_d1;
         2'd2: w_cur_digit = w_d2;
         2'd3: w_cur_digit = w_d3;
         default: w_cur_digit = w_d0;
      endcase
   end

   assign w_onehot_n = ~(4'b0001 << r_digit_idx);

   // A dark slot drives every pin inactive, not just the anodes.
   always_comb begin
      w_anode_nxt = 4'b1111;
      w_seg_nxt   = 7'b1111111;
      w_dp_nxt    = 1'b1;
      if (!bus.en) begin
         w_anode_nxt = 4'b1111;
      end else if (bus.blink_mask[r_digit_idx] && !r_blink_phase) begin
         w_anode_nxt = 4'b1111;
      end else if (!w_valid) begin
         w_anode_nxt = w_onehot_n;
         w_seg_nxt   = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
      end else if ((r_digit_idx == 2'd3) && (w_d3 == 4'd0)) begin
         w_anode_nxt = 4'b1111;
`endif
      end else begin
         w_anode_nxt = w_onehot_n;
         w_seg_nxt   = f_decode(w_cur_digit);
         w_dp_nxt    = (r_digit_idx == 2'd2) ? ~r_blink_phase : 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_anode <= 4'b1111;
         r_seg   <= 7'b1111111;
         r_dp    <= 1'b1;
      end else begin
         r_anode <= w_anode_nxt;
         r_seg   <= w_seg_nxt;
         r_dp    <= w_dp_nxt;
      end
   end

   assign bus.anode = r_anode;
   assign bus.seg   = r_seg;
   assign bus.dp    = r_dp;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - randomized self-checking bench against a cycle-count reference model
module tb_bcd_display_scanner;

   localparam int R = 4;
   localparam int B = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vec = 0;
   int   err = 0;

   bcd_display_scanner_if bus ();

   bcd_display_scanner #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          m_k;
   int          m_snap;
   logic [11:0] m_exp;

   function automatic logic [6:0] ref_seg(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   // Expected pins after the edge that sees cycle k since reset release.
   function automatic logic [11:0] model_out(input int k, input int snap, input logic en,
                                             input logic [3:0] mask);
      int idx;
      int ph;
      int d[4];
      logic ok;
      logic [3:0] an;
      idx  = (k / R) % 4;
      ph   = (k / B) % 2;
      d[0] = snap % 16;
      d[1] = (snap / 16) % 8;
      d[2] = (snap / 128) % 16;
      d[3] = snap / 2048;
      ok   = !(d[3] > 2 || d[2] > 9 || (d[3] == 2 && d[2] > 3) || d[1] > 5 || d[0] > 9);
      an   = 4'b1111;
      an[idx] = 1'b0;
      if (!en) return {4'b1111, 7'b1111111, 1'b1};
      if (mask[idx] && ph == 0) return {4'b1111, 7'b1111111, 1'b1};
      if (!ok) return {an, 7'b0111111, 1'b1};
`ifdef LEADING_ZERO_BLANK_EN
      if (idx == 3 && d[3] == 0) return {4'b1111, 7'b1111111, 1'b1};
`endif
      return {an, ref_seg(d[idx]), (idx == 2 && ph == 1) ? 1'b0 : 1'b1};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_k    <= 0;
         m_snap <= 0;
         m_exp  <= {4'b1111, 7'b1111111, 1'b1};
      end else begin
         m_exp  <= model_out(m_k, m_snap, bus.en, bus.blink_mask);
         if (m_k % (4 * R) == 4 * R - 1) m_snap <= int'(bus.count_in);
         m_k    <= m_k + 1;
      end
   end

   function automatic logic [13:0] rand_valid();
      int h10, h1, m10, m1;
      h10 = $urandom_range(0, 2);
      h1  = (h10 == 2) ? $urandom_range(0, 3) : $urandom_range(0, 9);
      m10 = $urandom_range(0, 5);
      m1  = $urandom_range(0, 9);
      return 14'(h10 * 2048 + h1 * 128 + m10 * 16 + m1);
   endfunction

   task automatic test_reset();
      bus.en = 1'b0; bus.count_in = 14'd0; bus.blink_mask = 4'd0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vec++;
      if ({bus.anode, bus.seg, bus.dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
         err++;
         $display("FAIL reset_state got=%b expected=%b", {bus.anode, bus.seg, bus.dp}, 12'b1111_1111111_1);
      end
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk); vec++;
         if ({bus.anode, bus.seg, bus.dp} !== m_exp) begin
            err++; $display("FAIL reset_idle got=%b expected=%b", {bus.anode, bus.seg, bus.dp}, m_exp);
         end
      end
   endtask

   task automatic test_frames_2359();
      bus.en = 1'b1; bus.blink_mask = 4'd0;
      bus.count_in = 14'b010_0011_101_1001;
      repeat (48) begin
         @(negedge clk); vec++;
         if ({bus.anode, bus.seg, bus.dp} !== m_exp) begin
            err++; $display("FAIL frames_2359 k=%0d got=%b expected=%b", m_k, {bus.anode, bus.seg, bus.dp}, m_exp);
         end
      end
   endtask

   task automatic test_midframe();
      int guard;
      guard = 0;
      while (m_k % (4 * R) != 6 && guard < 64) begin
         @(negedge clk); guard++;
      end
      vec++;
      if (guard >= 64) begin
         err++; $display("FAIL midframe_align got=%0d expected=6", m_k % (4 * R));
      end
      bus.count_in = 14'b001_0010_011_0100;
      repeat (40) begin
         @(negedge clk); vec++;
         if ({bus.anode, bus.seg, bus.dp} !== m_exp) begin
            err++; $display("FAIL midframe k=%0d got=%b expected=%b", m_k, {bus.anode, bus.seg, bus.dp}, m_exp);
         end
      end
   endtask

   task automatic test_invalid();
      logic [13:0] v;
      for (int i = 0; i < 6; i++) begin
         v = rand_valid();
         case (i % 5)
            0: v[13:11] = 3'(3 + $urandom_range(0, 4));
            1: v[10:7]  = 4'(10 + $urandom_range(0, 5));
            2: begin v[13:11] = 3'd2; v[10:7] = 4'(4 + $urandom_range(0, 5)); end
            3: v[6:4]   = 3'(6 + $urandom_range(0, 1));
            default: v[3:0] = 4'(10 + $urandom_range(0, 5));
         endcase
         bus.count_in = v;
         repeat (32) begin
            @(negedge clk); vec++;
            if ({bus.anode, bus.seg, bus.dp} !== m_exp) begin
               err++; $display("FAIL invalid v=%h got=%b expected=%b", v, {bus.anode, bus.seg, bus.dp}, m_exp);
            end
         end
      end
   endtask

   task automatic test_blink();
      bus.count_in = rand_valid();
      bus.blink_mask = 4'b1100;
      repeat (96) begin
         @(negedge clk); vec++;
         if ({bus.anode, bus.seg, bus.dp} !== m_exp) begin
            err++; $display("FAIL blink k=%0d got=%b expected=%b", m_k, {bus.anode, bus.seg, bus.dp}, m_exp);
         end
      end
      bus.blink_mask = 4'b0000;
   endtask

   task automatic test_enable();
      bus.count_in = rand_valid();
      @(negedge clk);
      bus.en = 1'b0;
      repeat (20) begin
         @(negedge clk); vec++;
         if ({bus.anode, bus.seg, bus.dp} !== m_exp) begin
            err++; $display("FAIL enable_off got=%b expected=%b", {bus.anode, bus.seg, bus.dp}, m_exp);
         end
      end
      bus.en = 1'b1;
      repeat (24) begin
         @(negedge clk); vec++;
         if ({bus.anode, bus.seg, bus.dp} !== m_exp) begin
            err++; $display("FAIL enable_resume k=%0d got=%b expected=%b", m_k, {bus.anode, bus.seg, bus.dp}, m_exp);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if (i % 23 == 0) begin
            bus.count_in   = ($urandom_range(0, 3) == 0) ? 14'($urandom) : rand_valid();
            bus.blink_mask = 4'($urandom);
            bus.en         = ($urandom_range(0, 7) != 0);
         end
         @(negedge clk); vec++;
         if ({bus.anode, bus.seg, bus.dp} !== m_exp) begin
            err++; $display("FAIL random k=%0d got=%b expected=%b", m_k, {bus.anode, bus.seg, bus.dp}, m_exp);
         end
         if (bus.anode != 4'b1111 && $countones(~bus.anode) != 1) begin
            err++; $display("FAIL random_onehot got=%b expected=one low bit", bus.anode);
         end
      end
   endtask

   task automatic test_async_reset();
      bus.en = 1'b1; bus.blink_mask = 4'd0;
      bus.count_in = 14'b010_0011_101_1001;
      repeat (21) @(negedge clk);
      #2 rst = 1'b0;
      #1 vec++;
      if ({bus.anode, bus.seg, bus.dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
         err++; $display("FAIL async_reset got=%b expected=%b", {bus.anode, bus.seg, bus.dp}, 12'b1111_1111111_1);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); vec++;
      if ({bus.anode, bus.seg, bus.dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
         err++; $display("FAIL post_reset_digit0 got=%b expected=%b", {bus.anode, bus.seg, bus.dp}, 12'b1110_1000000_1);
      end
      repeat (40) begin
         @(negedge clk); vec++;
         if ({bus.anode, bus.seg, bus.dp} !== m_exp) begin
            err++; $display("FAIL post_reset k=%0d got=%b expected=%b", m_k, {bus.anode, bus.seg, bus.dp}, m_exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_frames_2359();
      test_midframe();
      test_invalid();
      test_blink();
      test_enable();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
